element_pop_queue: RTL and testbench
====================================

# element_pop_queue

Bounded circular queue that is the consumer side of the team's queue element-select blocks: it accepts elements with push_back, hands them out in order via a valid/ready pop_front handshake, and lets a controller overwrite any live element by queue-relative index. It sits between a producer pushing int-sized words and a downstream consumer that drains them. Storage is a fixed DEPTH-entry RAM with head/tail pointers and an occupancy counter.

## Interface
- DEPTH, default 8: entries; power of two, at least 2.
- WIDTH, default 32: element width in bits.
- clk  input  1  sole clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- push_valid  input  1  producer offers push_data.
- push_data  input  WIDTH  element to append at the tail.
- push_ready  output  1  queue not full.
- pop_valid  output  1  queue not empty.
- pop_data  output  WIDTH  head element; 0 when empty.
- pop_ready  input  1  consumer takes head this cycle.
- wr_en  input  1  indexed overwrite request.
- wr_index  input  32  signed, queue-relative index (0 = head).
- wr_data  input  WIDTH  overwrite value.
- wr_err  output  1  registered pulse: previous wr_en had an out-of-range index.
- q_size  output  $clog2(DEPTH+1)  current occupancy.

## Operation
- Push fires when push_valid && push_ready: mem[tail] <= push_data, tail advances.
- Pop fires when pop_valid && pop_ready: head advances; the popped value is the pre-edge pop_data.
- Pointers wrap modulo DEPTH. q_size = previous value +1 on push only, -1 on pop only, unchanged on both or neither.
- Push and pop in the same cycle are both legal when 0 < q_size < DEPTH.
- Full: push_ready = 0. A push is not accepted even if a pop occurs in the same cycle; there is no bypass.
- Empty: pop_valid = 0 and pop_ready is ignored. There is no fall-through, so a pushed element appears on pop_data the cycle after acceptance.
- Indexed write is legal when 0 <= wr_index < q_size, evaluated with the pre-edge q_size. It writes mem[(head + wr_index) mod DEPTH] <= wr_data. Otherwise no write occurs and wr_err = 1 on the next cycle.
- Indexed write and push never target the same slot, because the tail slot is outside the live range.
- Indexed write to index 0 in the same cycle as a pop: the pop returns the old value and the write lands in the discarded slot, so it has no visible effect.
- Negative wr_index is always an error.

## Timing
- Reset values: head = tail = 0, q_size = 0, push_ready = 1, pop_valid = 0, pop_data = 0, wr_err = 0. Memory contents are not cleared.
- Reset in mid-operation discards every element and takes priority over push, pop and write in that cycle.
- push_ready, pop_valid, pop_data and q_size are combinational from registered state only, with no input-to-output path.
- Latencies: push to visible = 1 cycle; indexed write to visible on pop_data = 1 cycle; wr_err = 1 cycle after the request.

## Configuration
- ELEMENT_QUEUE_STATS_EN defined: adds output ports drop_cnt (16 bits) and peak_size (same width as q_size).
  - drop_cnt increments, saturating at 0xFFFF, for each push_valid while full and each pop_ready while empty.
  - peak_size holds the maximum q_size seen since reset.
  - Both reset to 0.
- ELEMENT_QUEUE_STATS_EN undefined: these ports and their logic are absent. Core behaviour is identical in both cases.

## Structure
- Package element_queue_pkg holds:
  - the function computing pointer width from DEPTH;
  - the size type;
  - the drop counter width constant (16);
  - the saturation-increment function.
- One sub-module, element_queue_mem: a DEPTH x WIDTH array with two synchronous write ports (push and indexed) and one asynchronous read port (head).
- Pointer, occupancy and handshake logic stay in element_pop_queue.

## Test plan
- Reset, then push 5, 7, 9 on consecutive cycles with pop_ready = 0 -> q_size = 3; pop_data = 5 one cycle after the first push.
- Fill to DEPTH = 8, then hold push_valid with push_data = 99 -> push_ready = 0, q_size stays 8, 99 is never popped; with the macro defined, drop_cnt counts each held cycle.
- Full queue with simultaneous push_valid and pop_ready -> pop accepted, push refused, q_size = 7.
- Queue holding 1, 2, 3: wr_en with index 2, data 42 -> pops return 1, 2, 42. Index 3 or -1 -> wr_err = 1 next cycle, contents unchanged.
- Push 10 elements while popping continuously to force pointer wrap -> output order matches input order and q_size never exceeds 1.
- Queue holding 4, 5: assert rst during a simultaneous push and pop -> next cycle q_size = 0, pop_valid = 0, pop_data = 0.

Source files
------------

// File: rtl/element_queue_pkg.sv
// Shared types and helpers for the element queue blocks: pointer sizing,
// the size type used for index range arithmetic, and the saturating counter.
package element_queue_pkg;

  localparam int DROP_CNT_W = 16;

  typedef logic [31:0]           size_t;
  typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic drop_cnt_t sat_inc(input drop_cnt_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/element_queue_mem.sv
// DEPTH x WIDTH element storage: two synchronous write ports (push, indexed)
// and one asynchronous read port for the head. Contents are never cleared.
module element_queue_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             push_we,
  input  logic [AW-1:0]    push_addr,
  input  logic [WIDTH-1:0] push_wdata,
  input  logic             idx_we,
  input  logic [AW-1:0]    idx_addr,
  input  logic [WIDTH-1:0] idx_wdata,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // The two ports never collide: the tail slot lies outside the live range.
  always_ff @(posedge clk) begin
    if (push_we) mem_q[push_addr] <= push_wdata;
    if (idx_we)  mem_q[idx_addr]  <= idx_wdata;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/element_pop_queue.sv
// Bounded circular queue with valid/ready pop, indexed overwrite; push visible after 1 cycle, push_ready low when full.
// Optional ELEMENT_QUEUE_STATS_EN adds drop_cnt and peak_size statistics ports.
module element_pop_queue
  import element_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_valid,
  input  logic [WIDTH-1:0]           push_data,
  output logic                       push_ready,
  output logic                       pop_valid,
  output logic [WIDTH-1:0]           pop_data,
  input  logic                       pop_ready,
  input  logic                       wr_en,
  input  logic [31:0]                wr_index,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       wr_err,
  output logic [$clog2(DEPTH+1)-1:0] q_size
`ifdef ELEMENT_QUEUE_STATS_EN
  ,
  output logic [DROP_CNT_W-1:0]      drop_cnt,
  output logic [$clog2(DEPTH+1)-1:0] peak_size
`endif
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_err_q;
  logic             push_fire, pop_fire, wr_ok;
  logic [WIDTH-1:0] head_data;

  assign push_ready = (count_q != CW'(DEPTH));
  assign pop_valid  = (count_q != '0);
  assign pop_data   = pop_valid ? head_data : '0;
  assign q_size     = count_q;
  assign wr_err     = wr_err_q;

  assign push_fire = push_valid & push_ready;
  assign pop_fire  = pop_valid & pop_ready;
  // Sign bit set means a negative index, which is never in range.
  assign wr_ok     = ~wr_index[31] && (wr_index < size_t'(count_q));

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_fire) tail_d = tail_q + 1'b1;
    if (pop_fire)  head_d = head_q + 1'b1;
    case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      wr_err_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      wr_err_q <= wr_en & ~wr_ok;
    end
  end

  element_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk        (clk),
    .push_we    (push_fire & ~rst),
    .push_addr  (tail_q),
    .push_wdata (push_data),
    .idx_we     (wr_en & wr_ok & ~rst),
    .idx_addr   (head_q + wr_index[AW-1:0]),
    .idx_wdata  (wr_data),
    .rd_addr    (head_q),
    .rd_data    (head_data)
  );

`ifdef ELEMENT_QUEUE_STATS_EN
  logic [DROP_CNT_W-1:0] drop_q;
  logic [CW-1:0]         peak_q;

  // Full and empty are exclusive, so at most one drop event per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
      peak_q <= '0;
    end else begin
      if ((push_valid & ~push_ready) | (pop_ready & ~pop_valid)) drop_q <= sat_inc(drop_q);
      if (count_d > peak_q) peak_q <= count_d;
    end
  end

  assign drop_cnt  = drop_q;
  assign peak_size = peak_q;
`endif

endmodule

// File: tb/tb_element_pop_queue.sv
// Randomized and directed bench for element_pop_queue against a queue-based reference model.
module tb_element_pop_queue;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst;
  logic             push_valid;
  logic [WIDTH-1:0] push_data;
  logic             push_ready;
  logic             pop_valid;
  logic [WIDTH-1:0] pop_data;
  logic             pop_ready;
  logic             wr_en;
  logic [31:0]      wr_index;
  logic [WIDTH-1:0] wr_data;
  logic             wr_err;
  logic [CW-1:0]    q_size;
`ifdef ELEMENT_QUEUE_STATS_EN
  logic [15:0]      drop_cnt;
  logic [CW-1:0]    peak_size;
`endif

  element_pop_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .pop_valid  (pop_valid),
    .pop_data   (pop_data),
    .pop_ready  (pop_ready),
    .wr_en      (wr_en),
    .wr_index   (wr_index),
    .wr_data    (wr_data),
    .wr_err     (wr_err),
    .q_size     (q_size)
`ifdef ELEMENT_QUEUE_STATS_EN
    ,
    .drop_cnt   (drop_cnt),
    .peak_size  (peak_size)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] mq[$];
  bit          m_err;
  int          m_drop;
  int          m_peak;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":q_size"},     32'(q_size),     32'(mq.size()));
    chk({tag, ":push_ready"}, 32'(push_ready), 32'(mq.size() < DEPTH));
    chk({tag, ":pop_valid"},  32'(pop_valid),  32'(mq.size() > 0));
    chk({tag, ":pop_data"},   pop_data,        (mq.size() > 0) ? mq[0] : 32'd0);
    chk({tag, ":wr_err"},     32'(wr_err),     32'(m_err));
`ifdef ELEMENT_QUEUE_STATS_EN
    chk({tag, ":drop_cnt"},   32'(drop_cnt),   32'(m_drop));
    chk({tag, ":peak_size"},  32'(peak_size),  32'(m_peak));
`endif
  endtask

  // One clock: drive inputs at negedge, check state-derived outputs, then
  // advance the model with the decisions the DUT makes at the rising edge.
  task automatic cycle(input string tag, input bit r, input bit pv, input logic [31:0] pd,
                       input bit pr, input bit we, input int wi, input logic [31:0] wd);
    bit full, empty, legal;
    rst = r; push_valid = pv; push_data = pd; pop_ready = pr;
    wr_en = we; wr_index = wi; wr_data = wd;
    check_outputs(tag);
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    legal = we && (wi >= 0) && (wi < mq.size());
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_err  = 0;
      m_drop = 0;
      m_peak = 0;
    end else begin
      if ((pv && full) || (pr && empty)) m_drop = (m_drop == 16'hFFFF) ? m_drop : m_drop + 1;
      if (legal) mq[wi] = wd;
      if (pr && !empty) void'(mq.pop_front());
      if (pv && !full) mq.push_back(pd);
      m_err = we && !legal;
      if (mq.size() > m_peak) m_peak = mq.size();
    end
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; push_valid = 0; push_data = 0; pop_ready = 0;
    wr_en = 0; wr_index = 0; wr_data = 0;
    m_err = 0; m_drop = 0; m_peak = 0;
    @(posedge clk);
    @(negedge clk);
    chk("reset:q_size",     32'(q_size),     32'd0);
    chk("reset:push_ready", 32'(push_ready), 32'd1);
    chk("reset:pop_valid",  32'(pop_valid),  32'd0);
    chk("reset:pop_data",   pop_data,        32'd0);
    chk("reset:wr_err",     32'(wr_err),     32'd0);

    // Push 5, 7, 9 with no pops
    cycle("push5", 0, 1, 5, 0, 0, 0, 0);
    chk("first_visible", pop_data, 32'd5);
    cycle("push7", 0, 1, 7, 0, 0, 0, 0);
    cycle("push9", 0, 1, 9, 0, 0, 0, 0);
    chk("three_pushed", 32'(q_size), 32'd3);

    // Fill to DEPTH and hold a refused push of 99
    cycle("rst_fill", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) cycle("fill", 0, 1, 32'(11 * (i + 1)), 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("hold99", 0, 1, 99, 0, 0, 0, 0);
    chk("full_q_size", 32'(q_size), 32'(DEPTH));
    chk("full_push_ready", 32'(push_ready), 32'd0);

    // Full with push and pop together: only the pop goes through
    cycle("full_pp", 0, 1, 99, 1, 0, 0, 0);
    chk("full_pp_q_size", 32'(q_size), 32'(DEPTH - 1));
    while (mq.size() > 0) cycle("drain", 0, 0, 0, 1, 0, 0, 0);
    cycle("pop_empty", 0, 0, 0, 1, 0, 0, 0);

    // Indexed write, then out-of-range indices
    cycle("rst_wr", 1, 0, 0, 0, 0, 0, 0);
    cycle("p1", 0, 1, 1, 0, 0, 0, 0);
    cycle("p2", 0, 1, 2, 0, 0, 0, 0);
    cycle("p3", 0, 1, 3, 0, 0, 0, 0);
    cycle("wr2", 0, 0, 0, 0, 1, 2, 42);
    cycle("wr3", 0, 0, 0, 0, 1, 3, 77);
    chk("wr3_err", 32'(wr_err), 32'd1);
    cycle("wrneg", 0, 0, 0, 0, 1, -1, 88);
    chk("wrneg_err", 32'(wr_err), 32'd1);
    cycle("pop1", 0, 0, 0, 1, 0, 0, 0);
    chk("after_pop1", pop_data, 32'd2);
    cycle("pop2", 0, 0, 0, 1, 0, 0, 0);
    chk("after_pop2", pop_data, 32'd42);
    cycle("pop42", 0, 0, 0, 1, 0, 0, 0);
    // Write to index 0 while popping is lost with the popped slot
    cycle("p6", 0, 1, 6, 0, 0, 0, 0);
    cycle("p8", 0, 1, 8, 0, 0, 0, 0);
    cycle("wr0pop", 0, 0, 0, 1, 1, 0, 55);
    chk("wr0pop_head", pop_data, 32'd8);
    cycle("pop8", 0, 0, 0, 1, 0, 0, 0);

    // Continuous push/pop across pointer wrap
    cycle("rst_wrap", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle("wrap", 0, 1, 32'(100 + i), 1, 0, 0, 0);
      chk("wrap_le1", 32'(q_size <= 1), 32'd1);
    end
    cycle("wrap_tail", 0, 0, 0, 1, 0, 0, 0);

    // Reset during simultaneous push and pop
    cycle("p4", 0, 1, 4, 0, 0, 0, 0);
    cycle("p5", 0, 1, 5, 0, 0, 0, 0);
    cycle("rst_pp", 1, 1, 6, 1, 1, 0, 9);
    chk("rst_pp_q_size",    32'(q_size),    32'd0);
    chk("rst_pp_pop_valid", 32'(pop_valid), 32'd0);
    chk("rst_pp_pop_data",  pop_data,       32'd0);

    // Randomized phase with shifting push/pop bias
    for (int i = 0; i < 600; i++) begin
      int pbias, qbias;
      pbias = ((i / 50) % 2 == 0) ? 3 : 1;
      qbias = ((i / 50) % 2 == 0) ? 1 : 3;
      cycle("rand",
            ($urandom_range(0, 99) == 0),
            ($urandom_range(0, 3) < pbias),
            $urandom,
            ($urandom_range(0, 3) < qbias),
            ($urandom_range(0, 3) == 0),
            $signed($urandom_range(0, DEPTH + 3)) - 2,
            $urandom);
    end
    idle("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
